// File: rtl/matrix_operand_loader.sv
// Stream-to-operand loader for matrix_mult_parallel: size word, then A and B row-major.
// Optional macro MATRIX_LOADER_ZERO_FILL_EN clears both operand arrays when a legal size is accepted.
module matrix_operand_loader #(
  parameter int unsigned MAX_SIZE = 10,
  parameter int unsigned DATA_W   = 32
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic [DATA_W-1:0]                     s_data,
  input  logic                                  s_valid,
  output logic                                  s_ready,
  output logic [31:0]                           matrix_size,
  output logic [MAX_SIZE*MAX_SIZE*DATA_W-1:0]   a_flat,
  output logic [MAX_SIZE*MAX_SIZE*DATA_W-1:0]   b_flat,
  output logic                                  mat_valid,
  input  logic                                  mat_ack,
  output logic                                  size_err
);

  localparam int unsigned CNT_W  = (MAX_SIZE > 15) ? $clog2(MAX_SIZE) : 4;
  localparam int unsigned FLAT_W = MAX_SIZE * MAX_SIZE * DATA_W;

  typedef enum logic [1:0] {
    ST_SIZE   = 2'd0,
    ST_LOAD_A = 2'd1,
    ST_LOAD_B = 2'd2,
    ST_HOLD   = 2'd3
  } state_t;

  state_t             state_q, state_nxt;
  logic [CNT_W-1:0]   row_q, col_q, row_nxt, col_nxt;
  logic [CNT_W-1:0]   last_idx;
  logic [31:0]        size_nxt;
  logic [31:0]        elem_idx;
  logic [FLAT_W-1:0]  a_nxt, b_nxt;
  logic               valid_nxt, ready_nxt, err_nxt;
  logic               xfer, size_ok, row_last, col_last;

  assign xfer     = s_valid && s_ready;
  assign size_ok  = (s_data != '0) && (s_data <= DATA_W'(MAX_SIZE));
  assign last_idx = CNT_W'(matrix_size - 32'd1);
  assign row_last = (row_q == last_idx);
  assign col_last = (col_q == last_idx);
  assign elem_idx = 32'(row_q) * MAX_SIZE + 32'(col_q);

  // State and all registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_SIZE;
      row_q       <= '0;
      col_q       <= '0;
      matrix_size <= '0;
      a_flat      <= '0;
      b_flat      <= '0;
      mat_valid   <= 1'b0;
      s_ready     <= 1'b0;
      size_err    <= 1'b0;
    end else begin
      state_q     <= state_nxt;
      row_q       <= row_nxt;
      col_q       <= col_nxt;
      matrix_size <= size_nxt;
      a_flat      <= a_nxt;
      b_flat      <= b_nxt;
      mat_valid   <= valid_nxt;
      s_ready     <= ready_nxt;
      size_err    <= err_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state_q;
    unique case (state_q)
      ST_SIZE:   if (xfer && size_ok) state_nxt = ST_LOAD_A;
      ST_LOAD_A: if (xfer && row_last && col_last) state_nxt = ST_LOAD_B;
      ST_LOAD_B: if (xfer && row_last && col_last) state_nxt = ST_HOLD;
      ST_HOLD:   if (mat_ack) state_nxt = ST_SIZE;
      default:   state_nxt = ST_SIZE;
    endcase
  end

  // Datapath and output next values; ready/valid are registered copies of the next state
  always_comb begin
    row_nxt   = row_q;
    col_nxt   = col_q;
    size_nxt  = matrix_size;
    a_nxt     = a_flat;
    b_nxt     = b_flat;
    err_nxt   = 1'b0;
    valid_nxt = (state_nxt == ST_HOLD);
    ready_nxt = (state_nxt != ST_HOLD);
    unique case (state_q)
      ST_SIZE: begin
        if (xfer) begin
          if (size_ok) begin
            size_nxt = 32'(s_data);
            row_nxt  = '0;
            col_nxt  = '0;
`ifdef MATRIX_LOADER_ZERO_FILL_EN
            a_nxt    = '0;
            b_nxt    = '0;
`endif
          end else begin
            err_nxt = 1'b1;
          end
        end
      end
      ST_LOAD_A, ST_LOAD_B: begin
        if (xfer) begin
          if (state_q == ST_LOAD_A) a_nxt[elem_idx*DATA_W +: DATA_W] = s_data;
          else                      b_nxt[elem_idx*DATA_W +: DATA_W] = s_data;
          if (col_last) begin
            col_nxt = '0;
            row_nxt = row_last ? '0 : row_q + CNT_W'(1);
          end else begin
            col_nxt = col_q + CNT_W'(1);
          end
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_matrix_operand_loader.sv
// Self-checking bench for matrix_operand_loader: directed frames plus random frames
// compared against an array-based reference of the loaded operands.
module tb_matrix_operand_loader;

  localparam int unsigned M  = 10;
  localparam int unsigned W  = 32;
  localparam int unsigned FW = M * M * W;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [W-1:0]  s_data;
  logic          s_valid;
  logic          s_ready;
  logic [31:0]   matrix_size;
  logic [FW-1:0] a_flat;
  logic [FW-1:0] b_flat;
  logic          mat_valid;
  logic          mat_ack;
  logic          size_err;

  int checks = 0;
  int errors = 0;
  int gap_lo = 0;
  int gap_hi = 0;

  logic [31:0] ea [M][M];
  logic [31:0] eb [M][M];
  logic [31:0] esize;
  logic [31:0] fa [M*M];
  logic [31:0] fb [M*M];

  always #5 clk = ~clk;

  matrix_operand_loader #(.MAX_SIZE(M), .DATA_W(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .s_data      (s_data),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .matrix_size (matrix_size),
    .a_flat      (a_flat),
    .b_flat      (b_flat),
    .mat_valid   (mat_valid),
    .mat_ack     (mat_ack),
    .size_err    (size_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    esize = 32'd0;
    for (int i = 0; i < M; i++)
      for (int j = 0; j < M; j++) begin
        ea[i][j] = 32'd0;
        eb[i][j] = 32'd0;
      end
  endtask

  // A frame of size n fills the top-left n x n block of each matrix in row-major order
  task automatic model_frame(input int n);
`ifdef MATRIX_LOADER_ZERO_FILL_EN
    for (int i = 0; i < M; i++)
      for (int j = 0; j < M; j++) begin
        ea[i][j] = 32'd0;
        eb[i][j] = 32'd0;
      end
`endif
    esize = 32'(n);
    for (int k = 0; k < n * n; k++) begin
      ea[k / n][k % n] = fa[k];
      eb[k / n][k % n] = fb[k];
    end
  endtask

  task automatic check_operands(input string tag);
    chk({tag, ".matrix_size"}, matrix_size, esize);
    for (int i = 0; i < M; i++)
      for (int j = 0; j < M; j++) begin
        chk($sformatf("%s.a[%0d][%0d]", tag, i, j), a_flat[(i*M+j)*W +: W], ea[i][j]);
        chk($sformatf("%s.b[%0d][%0d]", tag, i, j), b_flat[(i*M+j)*W +: W], eb[i][j]);
      end
  endtask

  // Called and returns just after a falling edge; the word transfers on the intervening rising edge
  task automatic push(input logic [31:0] w);
    int n;
    n = 0;
    repeat ($urandom_range(gap_hi, gap_lo)) @(negedge clk);
    s_data  = w;
    s_valid = 1'b1;
    while (!s_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("ready_timeout", 32'(s_ready), 32'd1);
    @(negedge clk);
    s_valid = 1'b0;
  endtask

  task automatic fill_random(input int n);
    for (int k = 0; k < n * n; k++) begin
      fa[k] = $urandom;
      fb[k] = $urandom;
    end
  endtask

  task automatic send_frame(input int n, input string tag);
    push(32'(n));
    for (int k = 0; k < n * n; k++) push(fa[k]);
    chk({tag, ".valid_mid"}, 32'(mat_valid), 32'd0);
    for (int k = 0; k < n * n; k++) push(fb[k]);
    model_frame(n);
    chk({tag, ".valid"}, 32'(mat_valid), 32'd1);
    chk({tag, ".ready_hold"}, 32'(s_ready), 32'd0);
    check_operands(tag);
  endtask

  task automatic hold_ack(input int delay, input string tag);
    repeat (delay) begin
      @(negedge clk);
      chk({tag, ".hold_valid"}, 32'(mat_valid), 32'd1);
      chk({tag, ".hold_ready"}, 32'(s_ready), 32'd0);
      check_operands({tag, ".hold"});
    end
    mat_ack = 1'b1;
    @(negedge clk);
    mat_ack = 1'b0;
    chk({tag, ".ack_valid"}, 32'(mat_valid), 32'd0);
    chk({tag, ".ack_ready"}, 32'(s_ready), 32'd1);
  endtask

  task automatic reject_size(input logic [31:0] w, input string tag);
    push(w);
    chk({tag, ".err"}, 32'(size_err), 32'd1);
    chk({tag, ".size_kept"}, matrix_size, esize);
    @(negedge clk);
    chk({tag, ".err_pulse"}, 32'(size_err), 32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst_n   = 1'b0;
    s_data  = '0;
    s_valid = 1'b0;
    mat_ack = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst.ready", 32'(s_ready), 32'd0);
    chk("rst.valid", 32'(mat_valid), 32'd0);
    chk("rst.err", 32'(size_err), 32'd0);
    check_operands("rst");
    rst_n = 1'b1;

    // N=2 back-to-back stream
    for (int k = 0; k < 4; k++) begin
      fa[k] = 32'(k + 1);
      fb[k] = 32'(k + 5);
    end
    send_frame(2, "n2");
    hold_ack(1, "n2");

    // Same frame, s_valid every other cycle, ack delayed 5 cycles
    gap_lo = 1; gap_hi = 1;
    send_frame(2, "n2_gap");
    hold_ack(5, "n2_gap");
    gap_lo = 0; gap_hi = 0;

    // Illegal sizes then a full-size frame
    reject_size(32'd0, "size0");
    reject_size(32'd11, "size11");
    fill_random(10);
    send_frame(10, "n10");
    chk("n10.a99", a_flat[99*W +: W], fa[99]);
    chk("n10.b99", b_flat[99*W +: W], fb[99]);
    hold_ack(0, "n10");

    // Reset in the middle of loading A
    push(32'd3);
    for (int k = 0; k < 3; k++) push($urandom);
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("midrst.ready", 32'(s_ready), 32'd0);
    chk("midrst.valid", 32'(mat_valid), 32'd0);
    chk("midrst.err", 32'(size_err), 32'd0);
    check_operands("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    fa[0] = 32'd7;
    fb[0] = 32'd9;
    send_frame(1, "n1");
    hold_ack(1, "n1");

    // Stale-element behaviour: N=3 then N=2
    fill_random(3);
    send_frame(3, "n3");
    hold_ack(0, "n3");
    fill_random(2);
    send_frame(2, "n2_after3");
`ifdef MATRIX_LOADER_ZERO_FILL_EN
    chk("stale.a22", a_flat[22*W +: W], 32'd0);
`else
    chk("stale.a22", a_flat[22*W +: W], ea[2][2]);
`endif

    // Ack and a new size word in the same cycle: word only taken once back in SIZE
    mat_ack = 1'b1;
    s_data  = 32'd2;
    s_valid = 1'b1;
    @(negedge clk);
    mat_ack = 1'b0;
    chk("ackword.ready", 32'(s_ready), 32'd1);
    chk("ackword.valid", 32'(mat_valid), 32'd0);
    @(negedge clk);
    s_valid = 1'b0;
    chk("ackword.size", matrix_size, 32'd2);
    fill_random(2);
    for (int k = 0; k < 4; k++) push(fa[k]);
    for (int k = 0; k < 4; k++) push(fb[k]);
    model_frame(2);
    chk("ackword.frame_valid", 32'(mat_valid), 32'd1);
    check_operands("ackword");
    hold_ack(2, "ackword");

    // Random frames with random gaps, rejects and ack delays
    gap_lo = 2; gap_hi = 0;
    for (int f = 0; f < 6; f++) begin
      if ($urandom_range(1, 0) == 1)
        reject_size(($urandom_range(1, 0) == 1) ? 32'd0 : 32'($urandom_range(200, 11)), "rnd.rej");
      n = $urandom_range(M, 1);
      fill_random(n);
      send_frame(n, $sformatf("rnd%0d", f));
      hold_ack($urandom_range(3, 0), $sformatf("rnd%0d", f));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
